// File: rtl/io_controller.sv
// I/O controller for the IN/OUT instructions: debounced button capture of the switches,
// and sequential binary-to-BCD conversion onto four active-low 7-segment displays.
module io_controller #(
  parameter int DATA_WIDTH      = 32,
  parameter int SW_WIDTH        = 18,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [1:0]            opIo,
  input  logic [SW_WIDTH-1:0]   switches,
  input  logic                  buttonN,
  input  logic [DATA_WIDTH-1:0] dataOut,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  waitFlag,
  output logic [27:0]           displays
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0]      SEG_DASH = 7'b1111110;
  localparam logic [6:0]      SEG_ZERO = 7'b0000001;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_IN_PRESS   = 3'd1,
    S_IN_RELEASE = 3'd2,
    S_OUT_CONV   = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync2_q, btn_q;
  logic [CNT_W-1:0]      db_cnt_q;
  logic [13:0]           conv_q, conv_d;
  logic                  over_q, over_d;
  logic [15:0]           bcd_q, bcd_d, bcd_next_s;
  logic [3:0]            iter_q, iter_d;
  logic [DATA_WIDTH-1:0] read_q, read_d;
  logic [27:0]           disp_q, disp_d;
  logic                  wait_s;

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  // One double-dabble step: correct digits >= 5, then shift in the next binary bit.
  function automatic logic [15:0] dabble_step(input logic [15:0] bcd, input logic bit_in);
    logic [15:0] adj;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return {adj[14:0], bit_in};
  endfunction

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      btn_q    <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= ~buttonN;
      sync2_q <= sync1_q;
      // btn follows the synchronized level only after an unbroken run of mismatches.
      if (sync2_q != btn_q) begin
        if (db_cnt_q == CNT_LAST) begin
          btn_q    <= sync2_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + CNT_W'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      conv_q  <= '0;
      over_q  <= 1'b0;
      bcd_q   <= '0;
      iter_q  <= '0;
      read_q  <= '0;
      disp_q  <= {4{SEG_ZERO}};
    end else begin
      state_q <= state_d;
      conv_q  <= conv_d;
      over_q  <= over_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      read_q  <= read_d;
      disp_q  <= disp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    conv_d     = conv_q;
    over_d     = over_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    read_d     = read_q;
    disp_d     = disp_q;
    bcd_next_s = dabble_step(bcd_q, conv_q[13]);
    case (state_q)
      S_IDLE: begin
        if (opIo == 2'b01) begin
          state_d = S_IN_PRESS;
        end else if (opIo == 2'b10) begin
          state_d = S_OUT_CONV;
          conv_d  = dataOut[13:0];
          over_d  = (dataOut > DATA_WIDTH'(14'd9999));
          bcd_d   = '0;
          iter_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IN_PRESS: begin
        if (btn_q) begin
          read_d  = DATA_WIDTH'(switches);
          state_d = S_IN_RELEASE;
        end else begin
          state_d = S_IN_PRESS;
        end
      end
      S_IN_RELEASE: begin
        if (!btn_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_IN_RELEASE;
        end
      end
      S_OUT_CONV: begin
        bcd_d  = bcd_next_s;
        conv_d = {conv_q[12:0], 1'b0};
        iter_d = iter_q + 4'd1;
        // The 14th shift completes the BCD value, so it is latched in the same cycle.
        if (iter_q == 4'd13) begin
          state_d = S_DONE;
          if (over_q) begin
            disp_d = {4{SEG_DASH}};
          end else begin
            disp_d = {seg7(bcd_next_s[15:12]), seg7(bcd_next_s[11:8]),
                      seg7(bcd_next_s[7:4]), seg7(bcd_next_s[3:0])};
          end
        end else begin
          state_d = S_OUT_CONV;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wait_s = 1'b0;
    case (state_q)
      S_IDLE:                               wait_s = (opIo == 2'b01) || (opIo == 2'b10);
      S_IN_PRESS, S_IN_RELEASE, S_OUT_CONV: wait_s = 1'b1;
      default:                              wait_s = 1'b0;
    endcase
  end

  // Gated by resetN so the PC never stalls while the controller is held in reset.
  assign waitFlag = resetN & wait_s;
  assign readData = read_q;
  assign displays = disp_q;

endmodule

// File: tb/tb_io_controller.sv
// Scoreboard bench for io_controller: stimulus pushes expected completions, a negedge
// monitor pops and compares them whenever an I/O stall ends.
module tb_io_controller;

  logic        clock = 1'b0;
  logic        resetN;
  logic [1:0]  opIo;
  logic [17:0] switches;
  logic        buttonN;
  logic [31:0] dataOut;
  logic [31:0] readData;
  logic        waitFlag;
  logic [27:0] displays;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  io_controller #(.DATA_WIDTH(32), .SW_WIDTH(18), .DEBOUNCE_CYCLES(4)) dut (
    .clock    (clock),
    .resetN   (resetN),
    .opIo     (opIo),
    .switches (switches),
    .buttonN  (buttonN),
    .dataOut  (dataOut),
    .readData (readData),
    .waitFlag (waitFlag),
    .displays (displays)
  );

  localparam logic [27:0] DISP_ZERO = {4{7'b0000001}};
  localparam logic [27:0] DISP_DASH = {4{7'b1111110}};

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  typedef struct {
    bit          is_out;
    logic [31:0] rd;
    logic [27:0] disp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_read = 32'd0;
  logic [27:0] m_disp = DISP_ZERO;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [27:0] disp_of(input logic [31:0] v);
    int n;
    if (v > 32'd9999) return DISP_DASH;
    n = int'(v);
    return {seg_tab[(n / 1000) % 10], seg_tab[(n / 100) % 10],
            seg_tab[(n / 10) % 10], seg_tab[n % 10]};
  endfunction

  // Monitor: a falling waitFlag marks the DONE cycle of a completed instruction.
  int stall     = 0;
  bit prev_wait = 1'b0;
  always @(negedge clock) begin
    if (!resetN) begin
      stall     = 0;
      prev_wait = 1'b0;
    end else begin
      if (waitFlag) begin
        stall++;
      end else if (prev_wait) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_completion actual=done required=none @%0t", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk(e.is_out ? "out_readData" : "in_readData", readData, e.rd);
          chk(e.is_out ? "out_displays" : "in_displays", {4'd0, displays}, {4'd0, e.disp});
          if (e.is_out) chk("out_stall_cycles", 32'(stall), 32'd15);
        end
        stall = 0;
      end
      prev_wait = waitFlag;
    end
  end

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (waitFlag && n < bound);
    checks++;
    if (waitFlag) begin
      failures++;
      $display("FAIL %s_timeout actual=still_waiting required=done_within_%0d @%0t", name, bound, $time);
    end
  endtask

  task automatic do_out(input logic [31:0] v);
    exp_t e;
    @(posedge clock); #1;
    m_disp = disp_of(v);
    e.is_out = 1'b1; e.rd = m_read; e.disp = m_disp;
    sb.push_back(e);
    opIo = 2'b10; dataOut = v;
    @(posedge clock); #1;
    dataOut = $urandom;
    wait_done("out", 40);
    opIo = 2'b00;
  endtask

  task automatic do_in(input logic [17:0] val, input int bounces, input int pre_wait,
                       input int press_len, input bit keep, input bit chained);
    exp_t e;
    @(posedge clock); #1;
    if (chained) chk("in_done_one_cycle", {31'd0, waitFlag}, 32'd1);
    m_read = {14'd0, val};
    e.is_out = 1'b0; e.rd = m_read; e.disp = m_disp;
    sb.push_back(e);
    opIo = 2'b01;
    repeat (pre_wait) begin
      switches = val ^ 18'($urandom_range(1, 262143));
      @(posedge clock); #1;
    end
    repeat (bounces) begin
      switches = val ^ 18'($urandom_range(1, 262143));
      buttonN = 1'b0;
      repeat (3) begin @(posedge clock); #1; end
      buttonN = 1'b1;
      repeat (3) begin @(posedge clock); #1; end
    end
    switches = val;
    buttonN = 1'b0;
    repeat (press_len) begin @(posedge clock); #1; end
    buttonN = 1'b1;
    wait_done("in", 60);
    switches = val ^ 18'($urandom_range(1, 262143));
    if (!keep) opIo = 2'b00;
  endtask

  task automatic mid_reset();
    resetN = 1'b0; #1;
    chk("rst_waitFlag", {31'd0, waitFlag}, 32'd0);
    chk("rst_readData", readData, 32'd0);
    chk("rst_displays", {4'd0, displays}, {4'd0, DISP_ZERO});
    @(posedge clock); @(posedge clock); #1;
    opIo = 2'b00; buttonN = 1'b1; resetN = 1'b1;
    m_read = 32'd0; m_disp = DISP_ZERO;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetN = 1'b1; opIo = 2'b10; buttonN = 1'b1; switches = 18'd0; dataOut = 32'd0;
    #2 resetN = 1'b0;
    #10;
    chk("reset_hold_waitFlag", {31'd0, waitFlag}, 32'd0);
    opIo = 2'b00;
    @(posedge clock); #1;
    resetN = 1'b1;
    @(posedge clock); #1;
    chk("reset_waitFlag", {31'd0, waitFlag}, 32'd0);
    chk("reset_readData", readData, 32'd0);
    chk("reset_displays", {4'd0, displays}, {4'd0, DISP_ZERO});

    do_out(32'd1234);
    do_out(32'd9999);
    do_out(32'd10000);
    do_out(32'h8000_0001);
    do_out(32'd0);
    do_out(32'd16383);

    do_in(18'h2A5F, 2, 0, 6, 1'b0, 1'b0);
    do_in(18'h1_2345, 0, 0, 30, 1'b1, 1'b0);
    do_in(18'h0_BEEF, 0, 20, 8, 1'b0, 1'b1);

    // Reset in the middle of a conversion.
    @(posedge clock); #1;
    opIo = 2'b10; dataOut = 32'd5678;
    repeat (5) begin @(posedge clock); #1; end
    mid_reset();
    do_out(32'd4321);

    do_in(18'h3_0F0F, 1, 0, 7, 1'b0, 1'b0);
    // Reset while waiting for the button release.
    @(posedge clock); #1;
    opIo = 2'b01; switches = 18'h3FFFF; buttonN = 1'b0;
    repeat (12) begin @(posedge clock); #1; end
    mid_reset();
    do_out(32'd56);

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 3))
          0:       do_out(32'($urandom_range(0, 9999)));
          1:       do_out(32'($urandom_range(10000, 16383)));
          2:       do_out($urandom);
          default: do_out(32'($urandom_range(0, 99)));
        endcase
      end else begin
        do_in(18'($urandom), $urandom_range(0, 2), $urandom_range(0, 4),
              $urandom_range(6, 9), 1'b0, 1'b0);
      end
    end

    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
